// File: rtl/vga_stream_monitor_pkg.sv
// Shared timing defaults, CRC constants and lock FSM states for the VGA stream monitor.
package vga_stream_monitor_pkg;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/crc16_ccitt_d16.sv
// Combinational CRC-16-CCITT step over one 16-bit word, MSB first.
module crc16_ccitt_d16
  import vga_stream_monitor_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [15:0] data,
  output logic [15:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int unsigned i = 0; i < 16; i++) begin
      if (crc_next[15] ^ data[4'(15 - i)])
        crc_next = {crc_next[14:0], 1'b0} ^ CRC16_POLY;
      else
        crc_next = {crc_next[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/vga_stream_monitor.sv
// Rebuilds raster position from hs/vs, checks sync timing and blanking,
// and publishes a per-frame CRC plus one probe pixel.
module vga_stream_monitor
  import vga_stream_monitor_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit SYNC_POL    = 1'b0,
  parameter int PIX_DELAY   = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic [4:0]  vga_r,
  input  logic [5:0]  vga_g,
  input  logic [4:0]  vga_b,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        clear,
  input  logic [10:0] probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic [15:0] frame_count,
  output logic [15:0] frame_crc,
  output logic        frame_crc_vld,
  output logic [15:0] probe_pixel,
  output logic        err_hperiod,
  output logic        err_vperiod,
  output logic        err_blank
);

  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP + PIX_DELAY);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + PIX_DELAY + H_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  lock_state_t state, state_next;
  logic [7:0]  acq_cnt, acq_next;

  logic        hs_act, vs_act, hs_d, vs_d, hs_lead, vs_lead;
  logic        vs_armed, h_seen, probe_arm;
  logic [10:0] h_cnt, pix_x, probe_xs;
  logic [9:0]  v_cnt, pix_y, probe_ys;
  logic [15:0] pix_d1, pix_d2, crc, crc_next;
  logic        frame_start, h_err, v_err, tim_err, in_active, publish;

  assign hs_act = (vga_hs == SYNC_POL);
  assign vs_act = (vga_vs == SYNC_POL);

  // Edge detect costs one clock and RGB lags sync by PIX_DELAY; delaying RGB by
  // two stages makes h_cnt equal the pixel's offset from the hs leading edge.
  assign frame_start = hs_lead & (vs_armed | vs_lead);
  assign h_err       = hs_lead & h_seen & (h_cnt != H_LAST);
  assign v_err       = frame_start & (v_cnt != V_LAST);
  assign tim_err     = (h_err | v_err) & (state != ST_UNLOCKED);
  assign in_active   = (h_cnt >= H_START) && (h_cnt < H_END) &&
                       (v_cnt >= V_START) && (v_cnt < V_END);
  assign publish     = frame_start & (state == ST_LOCKED) & ~tim_err;
  assign pix_x       = h_cnt - H_START;
  assign pix_y       = v_cnt - V_START;
  assign locked      = (state == ST_LOCKED);

  crc16_ccitt_d16 u_crc (
    .crc      (crc),
    .data     (pix_d2),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_UNLOCKED;
      acq_cnt <= '0;
    end else begin
      state   <= state_next;
      acq_cnt <= acq_next;
    end
  end

  always_comb begin
    state_next = state;
    acq_next   = acq_cnt;
    case (state)
      ST_UNLOCKED: if (frame_start) begin
        state_next = ST_ACQUIRE;
        acq_next   = '0;
      end
      ST_ACQUIRE: begin
        if (tim_err) state_next = ST_UNLOCKED;
        else if (frame_start) begin
          if (acq_cnt + 8'd1 == LOCK_N) state_next = ST_LOCKED;
          else acq_next = acq_cnt + 8'd1;
        end
      end
      ST_LOCKED: if (tim_err) state_next = ST_UNLOCKED;
      default: state_next = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hs_d <= 1'b0;  vs_d <= 1'b0;  hs_lead <= 1'b0;  vs_lead <= 1'b0;
      vs_armed <= 1'b0;  h_seen <= 1'b0;
      h_cnt <= '0;  v_cnt <= '0;
      pix_d1 <= '0;  pix_d2 <= '0;
      crc <= CRC16_INIT;
    end else begin
      hs_d    <= hs_act;
      vs_d    <= vs_act;
      hs_lead <= hs_act & ~hs_d;
      vs_lead <= vs_act & ~vs_d;
      pix_d1  <= {vga_r, vga_g, vga_b};
      pix_d2  <= pix_d1;

      if (hs_lead)            h_cnt <= '0;
      else if (h_cnt != '1)   h_cnt <= h_cnt + 11'd1;

      if (frame_start)                  v_cnt <= '0;
      else if (hs_lead && v_cnt != '1)  v_cnt <= v_cnt + 10'd1;

      if (frame_start)  vs_armed <= 1'b0;
      else if (vs_lead) vs_armed <= 1'b1;

      if (tim_err)      h_seen <= 1'b0;
      else if (hs_lead) h_seen <= 1'b1;

      if (frame_start)    crc <= CRC16_INIT;
      else if (in_active) crc <= crc_next;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;  frame_crc <= '0;  frame_crc_vld <= 1'b0;
      probe_pixel <= '0;  probe_xs <= '0;  probe_ys <= '0;  probe_arm <= 1'b0;
      err_hperiod <= 1'b0;  err_vperiod <= 1'b0;  err_blank <= 1'b0;
    end else begin
      frame_crc_vld <= publish;
      if (publish) frame_crc <= crc;

      if (clear)        frame_count <= '0;
      else if (publish) frame_count <= frame_count + 16'd1;

      err_hperiod <= (err_hperiod & ~clear) | (h_err & locked);
      err_vperiod <= (err_vperiod & ~clear) | (v_err & locked);
      err_blank   <= (err_blank & ~clear) | (locked & ~in_active & (pix_d2 != '0));

      if (frame_start) begin
        probe_xs  <= probe_x;
        probe_ys  <= probe_y;
        probe_arm <= 1'b1;
      end
      if (probe_arm && in_active && pix_x == probe_xs && pix_y == probe_ys)
        probe_pixel <= pix_d2;
    end
  end

endmodule
